julia_pixel_scheduler: RTL and testbench
========================================

Name: julia_pixel_scheduler

Overview:
- Downstream consumer of the HPS-exported view registers (init_x, init_y, step, num_iter).
- Walks every pixel of one frame in raster order and generates each pixel's complex coordinate by incremental addition.
- Hands pixels to the external Julia iterator array over a valid/ready handshake.
- Converts returned iteration counts to 8-bit colour, writes them into the on-chip VGA pixel buffer, and reports render time in ms back to the HPS export.

Parameters:
- H_RES, 640: pixels per row.
- V_RES, 480: rows per frame.
- CLK_PER_MS, 100000: clk cycles per millisecond (100 MHz).
- FX_W, 27: fixed-point coordinate width (two's complement 4.23).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start request
- auto_restart  in  1  when 1, a new frame starts automatically after frame_done
- init_x  in  FX_W  real coordinate of pixel (0,0)
- init_y  in  FX_W  imaginary coordinate of pixel (0,0)
- step  in  FX_W  coordinate increment per pixel/row
- num_iter  in  10  iteration limit
- pix_valid  out  1  pixel request valid
- pix_ready  in  1  iterator accepts request
- pix_c_re  out  FX_W  pixel real coordinate
- pix_c_im  out  FX_W  pixel imaginary coordinate
- pix_tag  out  19  buffer address of pixel
- pix_max_iter  out  10  latched iteration limit
- res_valid  in  1  result valid (no backpressure)
- res_iter  in  10  iterations reached
- res_tag  in  19  tag echoed from request
- buf_address  out  19  VGA buffer address
- buf_chipselect  out  1  buffer select
- buf_write  out  1  buffer write strobe
- buf_clken  out  1  buffer clock enable, tied 1 after reset
- buf_writedata  out  8  pixel colour
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame completion
- frame_ms  out  32  elapsed ms of last completed frame

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except buf_clken=1 after the first clock; counters, shadow registers, and frame_ms cleared. Reset mid-frame abandons the frame; the iterator shares reset_n.
- States and transitions:
  - IDLE -> ISSUE on start, or on auto_restart=1 one cycle after frame_done.
  - ISSUE -> DRAIN when the last pixel (col=H_RES-1, row=V_RES-1) handshakes.
  - DRAIN -> DONE when written count = H_RES*V_RES.
  - DONE -> IDLE after 1 cycle; frame_done=1 during that cycle.
- start while busy is ignored.
- On IDLE->ISSUE, init_x, init_y, step, and num_iter are latched into shadow registers. HPS changes mid-frame have no effect on the current frame.
- Coordinates:
  - c_re = init_x + col*step; c_im = init_y + row*step.
  - Computed incrementally: col advance adds step to c_re; end of row reloads c_re=init_x and adds step to row accumulator c_im.
  - Addition wraps mod 2^FX_W, no saturation.
  - pix_tag = row*H_RES + col, maintained as a running counter (no multiplier). Maximum value 307199.
- Handshake:
  - pix_valid high in ISSUE; transfer when pix_valid and pix_ready are both high.
  - pix_c_re, pix_c_im, and pix_tag are stable while pix_valid=1 and pix_ready=0.
  - Next pixel is presented the cycle after transfer, giving zero-bubble throughput of 1 pixel/cycle.
- Results:
  - Accepted every cycle res_valid=1 in ISSUE or DRAIN; may arrive out of order.
  - Ignored in IDLE and DONE.
  - Registered write, 1-cycle latency: buf_address=res_tag, buf_chipselect=buf_write=1 for one cycle.
- Colour:
  - res_iter >= latched num_iter -> 8'h00.
  - Otherwise {res_iter[2:0], res_iter[5:3], res_iter[7:6]} (RGB332).
- Simultaneous pixel issue and result write in the same cycle both count.
- Timer:
  - Prescaler counts clk in ISSUE/DRAIN and wraps at CLK_PER_MS-1, incrementing ms_count (32-bit, wraps).
  - Prescaler and ms_count clear on frame start.
  - frame_ms loads ms_count on entry to DONE and holds until the next DONE or reset.
- busy = 1 in ISSUE and DRAIN.

Test Plan:
- Reset, then start with init_x=0x7C00000, init_y=0x7E00000, step=0x0001000, num_iter=100, pix_ready=1 -> first three requests: c_re 0x7C00000/0x7C01000/0x7C02000, tags 0/1/2. Pixel 640 has c_re=0x7C00000, c_im=0x7E01000, tag 640.
- Echo-result model, 0 latency, res_iter=tag mod 128 -> buffer receives 307200 writes, one per address. Address 5 gets 8'hA0; iter 100 gets 8'h00. frame_done pulses exactly once.
- Random pix_ready (50%) and results reversed within 8-deep window -> outputs stable under stall; all 307200 addresses written once; DONE only after the last write.
- CLK_PER_MS=10, echo model with 0 latency -> frame_ms = 30720 or 30721. Change init_x mid-frame -> no change to coordinates of the current frame.
- Assert reset_n low mid-ISSUE at tag 1000 -> outputs 0 immediately, busy=0. Next start begins at tag 0. start pulse while busy -> ignored.
- auto_restart=1 -> second frame's first request appears 2 cycles after frame_done. res_valid asserted in IDLE -> no buffer write.

Source files
------------

// File: rtl/julia_pixel_scheduler_if.sv
// Pixel request, iteration result and VGA buffer write bundle between the
// frame scheduler (master) and the iterator array / pixel buffer (slave).
interface julia_pixel_scheduler_if #(
    parameter int FX_W = 27
);
    logic            pix_valid;
    logic            pix_ready;
    logic [FX_W-1:0] pix_c_re;
    logic [FX_W-1:0] pix_c_im;
    logic [18:0]     pix_tag;
    logic [9:0]      pix_max_iter;
    logic            res_valid;
    logic [9:0]      res_iter;
    logic [18:0]     res_tag;
    logic [18:0]     buf_address;
    logic            buf_chipselect;
    logic            buf_write;
    logic            buf_clken;
    logic [7:0]      buf_writedata;

    // Requests move when pix_valid && pix_ready at a rising clk edge; the
    // payload is held while pix_valid=1 and pix_ready=0. Results have no
    // backpressure: every res_valid cycle is one result.
    modport master (
        output pix_valid, pix_c_re, pix_c_im, pix_tag, pix_max_iter,
        input  pix_ready,
        input  res_valid, res_iter, res_tag,
        output buf_address, buf_chipselect, buf_write, buf_clken, buf_writedata
    );

    modport slave (
        input  pix_valid, pix_c_re, pix_c_im, pix_tag, pix_max_iter,
        output pix_ready,
        output res_valid, res_iter, res_tag,
        input  buf_address, buf_chipselect, buf_write, buf_clken, buf_writedata
    );
endinterface

// File: rtl/julia_pixel_scheduler.sv
// Raster-order pixel issuer for the Julia iterator array: incremental coordinate
// generation, result-to-RGB332 buffer writes and per-frame render timing.
module julia_pixel_scheduler #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int CLK_PER_MS = 100000,
    parameter int FX_W       = 27
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   auto_restart,
    input  logic [FX_W-1:0]        init_x,
    input  logic [FX_W-1:0]        init_y,
    input  logic [FX_W-1:0]        step,
    input  logic [9:0]             num_iter,
    julia_pixel_scheduler_if.master bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            frame_ms,
    output logic [1:0]             dbg_state
);
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [18:0] TOTAL = 19'(H_RES * V_RES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            done_last_q, done_last_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [18:0]     tag_q, tag_d;
    logic [FX_W-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
    logic [FX_W-1:0] sh_x_q, sh_x_d, sh_step_q, sh_step_d;
    logic [9:0]      sh_iter_q, sh_iter_d;
    logic [18:0]     wr_cnt_q, wr_cnt_d;
    logic [31:0]     prescale_q, prescale_d, ms_count_q, ms_count_d;
    logic [31:0]     frame_ms_q, frame_ms_d;
    logic            pix_valid_q, pix_valid_d, busy_q, busy_d, frame_done_q, frame_done_d;
    logic [18:0]     buf_address_q, buf_address_d;
    logic            buf_write_q, buf_write_d, buf_clken_q, buf_clken_d;
    logic [7:0]      buf_data_q, buf_data_d;
    logic            go, xfer, res_acc, last_col, last_row;
    logic [7:0]      colour;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        tag_d         = tag_q;
        c_re_d        = c_re_q;
        c_im_d        = c_im_q;
        sh_x_d        = sh_x_q;
        sh_step_d     = sh_step_q;
        sh_iter_d     = sh_iter_q;
        wr_cnt_d      = wr_cnt_q;
        prescale_d    = prescale_q;
        ms_count_d    = ms_count_q;
        buf_address_d = buf_address_q;
        buf_data_d    = buf_data_q;
        buf_clken_d   = 1'b1;
        done_last_d   = (state_q == DONE);

        // auto_restart only fires in the IDLE cycle that directly follows DONE
        go       = (state_q == IDLE) && (start || (auto_restart && done_last_q));
        xfer     = pix_valid_q && bus.pix_ready;
        res_acc  = bus.res_valid && busy_q;
        last_col = (col_q == COL_W'(H_RES - 1));
        last_row = (row_q == ROW_W'(V_RES - 1));

        if (bus.res_iter >= sh_iter_q) colour = 8'h00;
        else colour = {bus.res_iter[2:0], bus.res_iter[5:3], bus.res_iter[7:6]};

        case (state_q)
            IDLE: if (go) begin
                state_d    = ISSUE;
                sh_x_d     = init_x;
                sh_step_d  = step;
                sh_iter_d  = num_iter;
                c_re_d     = init_x;
                c_im_d     = init_y;
                col_d      = '0;
                row_d      = '0;
                tag_d      = '0;
                wr_cnt_d   = '0;
                prescale_d = '0;
                ms_count_d = '0;
            end
            ISSUE: if (xfer) begin
                if (last_col && last_row) begin
                    state_d = DRAIN;
                end else if (last_col) begin
                    col_d  = '0;
                    row_d  = row_q + 1'b1;
                    c_re_d = sh_x_q;
                    c_im_d = c_im_q + sh_step_q;
                    tag_d  = tag_q + 19'd1;
                end else begin
                    col_d  = col_q + 1'b1;
                    c_re_d = c_re_q + sh_step_q;
                    tag_d  = tag_q + 19'd1;
                end
            end
            DRAIN: if (wr_cnt_q == TOTAL) state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (res_acc) wr_cnt_d = wr_cnt_q + 19'd1;
        buf_write_d = res_acc;
        if (res_acc) begin
            buf_address_d = bus.res_tag;
            buf_data_d    = colour;
        end

        if (busy_q) begin
            if (prescale_q == 32'(CLK_PER_MS - 1)) begin
                prescale_d = '0;
                ms_count_d = ms_count_q + 32'd1;
            end else begin
                prescale_d = prescale_q + 32'd1;
            end
        end

        pix_valid_d  = (state_d == ISSUE);
        busy_d       = (state_d == ISSUE) || (state_d == DRAIN);
        frame_done_d = (state_d == DONE);
        // Includes the final DRAIN cycle's tick, so the time covers the whole frame
        frame_ms_d   = (state_d == DONE && state_q != DONE) ? ms_count_d : frame_ms_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            done_last_q   <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            tag_q         <= '0;
            c_re_q        <= '0;
            c_im_q        <= '0;
            sh_x_q        <= '0;
            sh_step_q     <= '0;
            sh_iter_q     <= '0;
            wr_cnt_q      <= '0;
            prescale_q    <= '0;
            ms_count_q    <= '0;
            frame_ms_q    <= '0;
            pix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            buf_address_q <= '0;
            buf_write_q   <= 1'b0;
            buf_clken_q   <= 1'b0;
            buf_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            done_last_q   <= done_last_d;
            col_q         <= col_d;
            row_q         <= row_d;
            tag_q         <= tag_d;
            c_re_q        <= c_re_d;
            c_im_q        <= c_im_d;
            sh_x_q        <= sh_x_d;
            sh_step_q     <= sh_step_d;
            sh_iter_q     <= sh_iter_d;
            wr_cnt_q      <= wr_cnt_d;
            prescale_q    <= prescale_d;
            ms_count_q    <= ms_count_d;
            frame_ms_q    <= frame_ms_d;
            pix_valid_q   <= pix_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            buf_address_q <= buf_address_d;
            buf_write_q   <= buf_write_d;
            buf_clken_q   <= buf_clken_d;
            buf_data_q    <= buf_data_d;
        end
    end

    assign bus.pix_valid      = pix_valid_q;
    assign bus.pix_c_re       = c_re_q;
    assign bus.pix_c_im       = c_im_q;
    assign bus.pix_tag        = tag_q;
    assign bus.pix_max_iter   = sh_iter_q;
    assign bus.buf_address    = buf_address_q;
    assign bus.buf_chipselect = buf_write_q;
    assign bus.buf_write      = buf_write_q;
    assign bus.buf_clken      = buf_clken_q;
    assign bus.buf_writedata  = buf_data_q;
    assign busy               = busy_q;
    assign frame_done         = frame_done_q;
    assign frame_ms           = frame_ms_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// Bench for julia_pixel_scheduler on a reduced 16x8 frame: spot-value table,
// randomized frames against a coordinate/colour model, reset and restart sequences.
module tb_julia_pixel_scheduler;
  localparam int H_RES = 16;
  localparam int V_RES = 8;
  localparam int CLK_PER_MS = 10;
  localparam int FX_W = 27;
  localparam int N = H_RES * V_RES;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic auto_restart = 1'b0;
  logic [FX_W-1:0] init_x = '0, init_y = '0, step = '0;
  logic [9:0] num_iter = '0;
  logic busy, frame_done;
  logic [31:0] frame_ms;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  julia_pixel_scheduler_if #(.FX_W(FX_W)) bus();

  julia_pixel_scheduler #(
    .H_RES(H_RES), .V_RES(V_RES), .CLK_PER_MS(CLK_PER_MS), .FX_W(FX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .auto_restart(auto_restart),
    .init_x(init_x), .init_y(init_y), .step(step), .num_iter(num_iter),
    .bus(bus.master), .busy(busy), .frame_done(frame_done),
    .frame_ms(frame_ms), .dbg_state(dbg_state)
  );

  // scoreboard and reference model state
  int checks = 0;
  int failures = 0;
  logic [FX_W-1:0] m_x, m_y, m_step;
  logic [9:0] m_lim;
  int m_idx;
  int m_iter[N];
  int wr_cnt[N];
  int frame_wr;
  int done_cnt;
  bit saw_done;
  logic [26:0] exp_q[$];
  int batch_q[$];
  int out_q[$];
  int ready_pct = 100;
  bit reorder = 1'b0;
  bit iter_rand = 1'b0;
  logic [FX_W-1:0] obs_re[N];
  logic [FX_W-1:0] obs_im[N];
  logic [7:0] obs_col[N];

  typedef struct {
    int fr;
    int tag;
    logic [26:0] re;
    logic [26:0] im;
    logic [7:0] col;
  } tv_t;
  tv_t tv[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RGB332 from plain arithmetic: red = iter mod 8, green = (iter/8) mod 8, blue = (iter/64) mod 4
  function automatic logic [7:0] colour(input int iter, input int lim);
    if (iter >= lim) return 8'h00;
    return 8'((iter % 8) * 32 + ((iter / 8) % 8) * 4 + (iter / 64) % 4);
  endfunction

  task automatic frame_begin();
    m_x = init_x;
    m_y = init_y;
    m_step = step;
    m_lim = num_iter;
    m_idx = 0;
    frame_wr = 0;
    done_cnt = 0;
    batch_q.delete();
    out_q.delete();
    for (int t = 0; t < N; t++) begin
      wr_cnt[t] = 0;
      m_iter[t] = iter_rand ? int'($urandom_range(1023)) : t % 128;
    end
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs.
  task automatic cycle();
    logic [26:0] w;
    logic [63:0] er, ei;
    int tag;
    int a;
    @(negedge clk);
    start = 1'b0;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("buf_write", 64'(bus.buf_write), 64'd1);
      chk("buf_chipselect", 64'(bus.buf_chipselect), 64'd1);
      chk("buf_address", 64'(bus.buf_address), 64'(w[26:8]));
      chk("buf_writedata", 64'(bus.buf_writedata), 64'(w[7:0]));
    end else begin
      chk("buf_write_idle", 64'(bus.buf_write), 64'd0);
    end
    if (bus.buf_write) begin
      frame_wr++;
      a = int'(bus.buf_address);
      if (a < N) begin
        wr_cnt[a]++;
        obs_col[a] = bus.buf_writedata;
      end
    end
    saw_done = frame_done;
    if (frame_done) begin
      done_cnt++;
      chk("done_after_writes", 64'(frame_wr), 64'(N));
    end
    bus.pix_ready = (int'($urandom_range(99)) < ready_pct);
    if (bus.pix_valid) begin
      if (m_idx >= N) begin
        chk("pix_extra_valid", 64'(bus.pix_valid), 64'd0);
      end else begin
        er = 64'(m_x) + 64'(m_idx % H_RES) * 64'(m_step);
        ei = 64'(m_y) + 64'(m_idx / H_RES) * 64'(m_step);
        chk("pix_c_re", 64'(bus.pix_c_re), 64'(er[FX_W-1:0]));
        chk("pix_c_im", 64'(bus.pix_c_im), 64'(ei[FX_W-1:0]));
        chk("pix_tag", 64'(bus.pix_tag), 64'(m_idx));
        chk("pix_max_iter", 64'(bus.pix_max_iter), 64'(m_lim));
        if (bus.pix_ready) begin
          obs_re[m_idx] = bus.pix_c_re;
          obs_im[m_idx] = bus.pix_c_im;
          if (reorder) batch_q.push_back(m_idx);
          else out_q.push_back(m_idx);
          m_idx++;
        end
      end
    end
    if (reorder && batch_q.size() > 0 && (batch_q.size() == 8 || m_idx == N)) begin
      while (batch_q.size() > 0) out_q.push_back(batch_q.pop_back());
    end
    if (out_q.size() > 0) begin
      tag = out_q.pop_front();
      bus.res_valid = 1'b1;
      bus.res_tag = 19'(tag);
      bus.res_iter = 10'(m_iter[tag]);
      exp_q.push_back({19'(tag), colour(m_iter[tag], int'(m_lim))});
    end else begin
      bus.res_valid = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [FX_W-1:0] x, input logic [FX_W-1:0] y,
                             input logic [FX_W-1:0] s, input logic [9:0] n);
    init_x = x;
    init_y = y;
    step = s;
    num_iter = n;
    start = 1'b1;
    frame_begin();
    cycle();
  endtask

  // Runs until frame_done; a third of the way in, the view registers change
  // and start is pulsed, neither of which may disturb the running frame.
  task automatic run_frame(input int tail);
    int n;
    int bad;
    bit disturbed;
    n = 0;
    disturbed = 1'b0;
    saw_done = 1'b0;
    while (!saw_done && n < 3000) begin
      if (!disturbed && m_idx == N / 3) begin
        init_x = FX_W'($urandom);
        init_y = FX_W'($urandom);
        step = FX_W'($urandom);
        num_iter = 10'($urandom);
        start = 1'b1;
        disturbed = 1'b1;
      end
      cycle();
      n++;
    end
    chk("frame_completed", 64'(saw_done), 64'd1);
    repeat (tail) cycle();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("pixels_issued", 64'(m_idx), 64'(N));
    bad = 0;
    for (int t = 0; t < N; t++) if (wr_cnt[t] != 1) bad++;
    chk("writes_once", 64'(bad), 64'd0);
  endtask

  task automatic check_table(input int fr);
    for (int i = 0; i < 13; i++) begin
      if (tv[i].fr == fr) begin
        chk("tv_c_re", 64'(obs_re[tv[i].tag]), 64'(tv[i].re));
        chk("tv_c_im", 64'(obs_im[tv[i].tag]), 64'(tv[i].im));
        chk("tv_colour", 64'(obs_col[tv[i].tag]), 64'(tv[i].col));
      end
    end
  endtask

  task automatic set_tv(input int i, input int fr, input int tag, input logic [26:0] re,
                        input logic [26:0] im, input logic [7:0] col);
    tv[i].fr = fr;
    tv[i].tag = tag;
    tv[i].re = re;
    tv[i].im = im;
    tv[i].col = col;
  endtask

  task automatic check_ms();
    chk("frame_ms_range",
        64'((frame_ms == 32'(N / CLK_PER_MS)) || (frame_ms == 32'(N / CLK_PER_MS + 1))), 64'd1);
  endtask

  initial begin
    // frame 1: 0x7C00000/0x7E00000 step 0x1000, iter = tag, limit 100
    set_tv(0, 1, 0,   27'h7C00000, 27'h7E00000, 8'h00);
    set_tv(1, 1, 1,   27'h7C01000, 27'h7E00000, 8'h20);
    set_tv(2, 1, 2,   27'h7C02000, 27'h7E00000, 8'h40);
    set_tv(3, 1, 5,   27'h7C05000, 27'h7E00000, 8'hA0);
    set_tv(4, 1, 16,  27'h7C00000, 27'h7E01000, 8'h08);
    set_tv(5, 1, 73,  27'h7C09000, 27'h7E04000, 8'h25);
    set_tv(6, 1, 99,  27'h7C03000, 27'h7E06000, 8'h71);
    set_tv(7, 1, 100, 27'h7C04000, 27'h7E06000, 8'h00);
    set_tv(8, 1, 127, 27'h7C0F000, 27'h7E07000, 8'h00);
    // frame 2: coordinates wrap through 2^27
    set_tv(9,  2, 0,  27'h7FFF000, 27'h7FFF800, 8'h00);
    set_tv(10, 2, 1,  27'h0000000, 27'h7FFF800, 8'h20);
    set_tv(11, 2, 16, 27'h7FFF000, 27'h0000800, 8'h08);
    set_tv(12, 2, 17, 27'h0000000, 27'h0000800, 8'h28);

    bus.pix_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_iter = '0;
    bus.res_tag = '0;
    frame_begin();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_ms", 64'(frame_ms), 64'd0);
    chk("rst_buf_write", 64'(bus.buf_write), 64'd0);
    chk("rst_buf_cs", 64'(bus.buf_chipselect), 64'd0);
    chk("rst_buf_address", 64'(bus.buf_address), 64'd0);
    chk("rst_buf_clken", 64'(bus.buf_clken), 64'd0);
    reset_n = 1'b1;
    cycle();
    chk("buf_clken_after_reset", 64'(bus.buf_clken), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // frame 1: full ready, zero-latency echo
    ready_pct = 100;
    reorder = 1'b0;
    iter_rand = 1'b0;
    start_frame(27'h7C00000, 27'h7E00000, 27'h0001000, 10'd100);
    run_frame(4);
    check_table(1);
    check_ms();

    // results in IDLE must not write
    bus.res_valid = 1'b1;
    bus.res_tag = 19'd5;
    bus.res_iter = 10'd1;
    @(negedge clk);
    chk("idle_res_write", 64'(bus.buf_write), 64'd0);
    @(negedge clk);
    chk("idle_res_write2", 64'(bus.buf_write), 64'd0);
    bus.res_valid = 1'b0;
    cycle();

    // frame 2: wrap-around coordinates
    start_frame(27'h7FFF000, 27'h7FFF800, 27'h0001000, 10'd100);
    run_frame(3);
    check_table(2);

    // random frames: 50% ready, results reversed in 8-deep windows
    ready_pct = 50;
    reorder = 1'b1;
    iter_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      start_frame(FX_W'($urandom), FX_W'($urandom), FX_W'($urandom),
                  10'($urandom_range(1023, 1)));
      run_frame(3);
    end

    // reset mid-ISSUE at tag 50
    ready_pct = 100;
    reorder = 1'b0;
    iter_rand = 1'b0;
    start_frame(27'h7C00000, 27'h7E00000, 27'h0001000, 10'd100);
    for (int n = 0; n < 200 && m_idx < 50; n++) cycle();
    reset_n = 1'b0;
    #1;
    chk("midrst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_buf_write", 64'(bus.buf_write), 64'd0);
    chk("midrst_frame_ms", 64'(frame_ms), 64'd0);
    bus.res_valid = 1'b0;
    exp_q.delete();
    frame_begin();
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
    start_frame(27'h0123000, 27'h0456000, 27'h0000800, 10'd60);
    run_frame(3);
    check_ms();

    // auto restart: next frame's first request two cycles after frame_done
    auto_restart = 1'b1;
    start_frame(27'h7C00000, 27'h7E00000, 27'h0001000, 10'd100);
    run_frame(0);
    frame_begin();
    cycle();
    chk("auto_gap_idle", 64'(bus.pix_valid), 64'd0);
    cycle();
    chk("auto_gap_valid", 64'(bus.pix_valid), 64'd1);
    auto_restart = 1'b0;
    run_frame(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
